// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight destinations, selects forwarding
// sources per operand and stalls the front end on load-use dependencies.
module pipeline_hazard_ctrl #(
  parameter int  REGISTER_SIZE = 5,
  parameter int  NUM_SRC       = 2,
  parameter int  FWD_STAGES    = 3,
  parameter int  LOAD_LAT      = 1,
  parameter int  CNT_W         = 16,
  localparam int FWD_SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [NUM_SRC*REGISTER_SIZE-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]               id_src_used,
  input  logic [REGISTER_SIZE-1:0]         id_rd_addr,
  input  logic                             id_rd_we,
  input  logic                             id_is_load,
  input  logic                             flush,
  input  logic                             ext_stall,
  input  logic                             cnt_clr,
  output logic                             f_to_d_enable,
  output logic                             d_to_e_enable,
  output logic                             bubble,
  output logic [NUM_SRC*FWD_SEL_W-1:0]     fwd_sel,
  output logic [FWD_STAGES-1:0]            stage_valid,
  output logic [CNT_W-1:0]                 stall_count
);

  // Array index k holds pipeline stage k+1 (index 0 = execute).
  logic [FWD_STAGES-1:0]    stg_valid_q, stg_valid_d;
  logic [FWD_STAGES-1:0]    stg_we_q, stg_we_d;
  logic [FWD_STAGES-1:0]    stg_ld_q, stg_ld_d;
  logic [REGISTER_SIZE-1:0] stg_rd_q [FWD_STAGES];
  logic [REGISTER_SIZE-1:0] stg_rd_d [FWD_STAGES];
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [FWD_STAGES-1:0]        cand_s;
  logic [FWD_STAGES-1:0]        hit_s [NUM_SRC];
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_s;
  logic                         lu_s;
  logic                         hold_s;
  logic                         ins_s;
  logic                         inc_s;

  // Forwarding candidates and per-operand stage matches (x0 never matches).
  always_comb begin
    cand_s = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      cand_s[k] = stg_valid_q[k] & stg_we_q[k] & (|stg_rd_q[k]);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s[i] = '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        hit_s[i][k] = id_src_used[i] & cand_s[k] &
                      (stg_rd_q[k] == id_src_addr[i*REGISTER_SIZE +: REGISTER_SIZE]);
      end
    end
  end

  // Youngest matching stage wins the select; any young load match is a load-use hazard.
  always_comb begin
    fwd_sel_s = '0;
    lu_s      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        fwd_sel_s[i*FWD_SEL_W +: FWD_SEL_W] = hit_s[i][k] ? FWD_SEL_W'(k + 1)
                                                          : fwd_sel_s[i*FWD_SEL_W +: FWD_SEL_W];
        lu_s = lu_s | (id_valid & hit_s[i][k] & stg_ld_q[k] & (k < LOAD_LAT));
      end
    end
  end

  // Pipeline control with priority ext_stall > flush > load-use > normal.
  always_comb begin
    f_to_d_enable = 1'b1;
    d_to_e_enable = 1'b1;
    bubble        = 1'b0;
    hold_s        = 1'b0;
    ins_s         = 1'b0;
    inc_s         = 1'b0;
    if (ext_stall) begin
      f_to_d_enable = 1'b0;
      d_to_e_enable = 1'b0;
      hold_s        = 1'b1;
    end else if (flush) begin
      bubble = 1'b1;
    end else if (lu_s) begin
      f_to_d_enable = 1'b0;
      d_to_e_enable = 1'b0;
      bubble        = 1'b1;
      inc_s         = 1'b1;
    end else begin
      ins_s = 1'b1;
    end
  end

  // Next state of the stage tracker and the saturating stall counter.
  always_comb begin
    stg_rd_d = stg_rd_q;
    if (hold_s) begin
      stg_valid_d = stg_valid_q;
      stg_we_d    = stg_we_q;
      stg_ld_d    = stg_ld_q;
    end else begin
      stg_valid_d = {stg_valid_q[FWD_STAGES-2:0], ins_s & id_valid};
      stg_we_d    = {stg_we_q[FWD_STAGES-2:0], ins_s & id_valid & id_rd_we};
      stg_ld_d    = {stg_ld_q[FWD_STAGES-2:0], ins_s & id_valid & id_is_load};
      stg_rd_d[0] = ins_s ? id_rd_addr : {REGISTER_SIZE{1'b0}};
      for (int k = 1; k < FWD_STAGES; k++) begin
        stg_rd_d[k] = stg_rd_q[k-1];
      end
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (inc_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid_q <= '0;
      stg_we_q    <= '0;
      stg_ld_q    <= '0;
      cnt_q       <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        stg_rd_q[k] <= {REGISTER_SIZE{1'b0}};
      end
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_we_q    <= stg_we_d;
      stg_ld_q    <= stg_ld_d;
      cnt_q       <= cnt_d;
      stg_rd_q    <= stg_rd_d;
    end
  end

  assign fwd_sel     = fwd_sel_s;
  assign stage_valid = stg_valid_q;
  assign stall_count = cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- REGISTER_SIZE, 5: register address width.
- NUM_SRC, 2: number of decode source operands.
- FWD_STAGES, 3: number of tracked post-decode stages (1 = execute, 2 = memory access, 3 = writeback).
- LOAD_LAT, 1: number of stages, starting at stage 1, in which a load result is not yet available (legal range 1..FWD_STAGES-1).
- CNT_W, 16: stall counter width.
REQ-002 Derived width: FWD_SEL_W = clog2(FWD_STAGES+1).
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- id_valid, in, 1: decode stage holds a valid instruction.
- id_src_addr, in, NUM_SRC*REGISTER_SIZE: source register addresses; operand i is slice i.
- id_src_used, in, NUM_SRC: operand i is read by the instruction.
- id_rd_addr, in, REGISTER_SIZE: destination register.
- id_rd_we, in, 1: instruction writes the register file.
- id_is_load, in, 1: instruction is a load.
- flush, in, 1: redirect from execute; kills the decode instruction.
- ext_stall, in, 1: freeze the whole pipeline.
- cnt_clr, in, 1: synchronous clear of stall_count.
- f_to_d_enable, out, 1: fetch-to-decode flop enable.
- d_to_e_enable, out, 1: decode-to-execute flop enable.
- bubble, out, 1: load a NOP into the execute stage this edge.
- fwd_sel, out, NUM_SRC*FWD_SEL_W: per-operand source select; 0 = register file, k = stage k result.
- stage_valid, out, FWD_STAGES: valid bit of each tracked stage.
- stall_count, out, CNT_W: load-use stall cycles.

Function
REQ-004 The block holds a FWD_STAGES-deep shift register; each entry holds {valid, rd, we, is_load}.
REQ-005 Entry k is a forwarding candidate only if valid=1, we=1 and rd!=0.
REQ-006 fwd_sel[i] is combinational: the lowest stage k whose candidate rd equals src i, provided id_src_used[i]=1; otherwise fwd_sel[i]=0.
REQ-007 A source address of x0 always gives fwd_sel=0.
REQ-008 Load-use hazard (lu): id_valid=1 and some used src i matches a candidate entry k with is_load=1 and k<=LOAD_LAT.
REQ-009 Priority order is ext_stall > flush > lu > normal.
REQ-010 ext_stall=1:
- f_to_d_enable=0, d_to_e_enable=0, bubble=0.
- Shift register and stall_count hold.
- flush is ignored; the requester holds flush until ext_stall=0.
REQ-011 flush=1 (ext_stall=0):
- f_to_d_enable=1, d_to_e_enable=1, bubble=1.
- Entry 1 loads valid=0; the register shifts.
- The lu stall is suppressed and stall_count does not increment.
REQ-012 lu=1 (no ext_stall, no flush):
- f_to_d_enable=0, d_to_e_enable=0, bubble=1.
- Entry 1 loads valid=0; entries shift.
- stall_count increments.
REQ-013 Normal operation:
- f_to_d_enable=1, d_to_e_enable=1, bubble=0.
- Entry 1 loads {id_valid, id_rd_addr, id_rd_we & id_valid, id_is_load & id_valid}.
- Entry k loads entry k-1.
REQ-014 A stall lasts as long as lu holds. The load advances one stage per cycle, so a LOAD_LAT=1 load stalls exactly 1 cycle and a LOAD_LAT=L load stalls up to L cycles.
REQ-015 stall_count saturates at 2^CNT_W-1. cnt_clr=1 sets it to 0 on the next edge; if cnt_clr and an increment occur together, the clear wins.
REQ-016 The oldest entry is discarded on every shift; no wrap-around.
REQ-017 All outputs except stall_count and stage_valid are combinational from the inputs and the registered state.

Reset
REQ-018 rst=0 asynchronously clears all entries to zero and sets stall_count=0.
REQ-019 During reset, outputs are: stage_valid=0, fwd_sel=0, bubble=0, f_to_d_enable=1, d_to_e_enable=1.
REQ-020 Reset deasserted mid-stall: the first cycle after reset shows no stall, because all entries are invalid.
REQ-021 rst deassertion is synchronised externally to clk.

Verification
REQ-022 Back-to-back ALU dependency: add x5 issued, then a next instruction with src0=x5 -> fwd_sel[0]=1; one cycle later, with src1=x5 -> fwd_sel[1]=2; no stall.
REQ-023 Load-use: lw x7 issued, then src0=x7 -> bubble=1 and both enables=0 for 1 cycle; next cycle fwd_sel[0]=2 and stall_count=1.
REQ-024 Priority: x3 written in stages 1 and 3 and src0=x3 -> fwd_sel[0]=1. Destination x0 with src0=x0 -> fwd_sel[0]=0.
REQ-025 flush and lu in the same cycle -> bubble=1, enables=1, stall_count unchanged. ext_stall held for 3 cycles -> stage_valid constant and enables=0.
REQ-026 Saturation and reset:
- With CNT_W=2, 5 lu cycles -> stall_count=3.
- cnt_clr together with lu -> stall_count=0.
- rst=0 pulsed mid-stall -> stage_valid=0 immediately, without waiting for a clock edge.
